user_proj_yblock: RTL and testbench

// - Caravel user-area wrapper holding one 16x16 Morphle-style cell array (yblock),

---
 rtl/user_proj_yblock_if.sv | 29 ++
 rtl/user_proj_yblock.sv | 136 +++++++++++++
 tb/tb_user_proj_yblock.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/user_proj_yblock_if.sv
// rtl/user_proj_yblock_if.sv - LA, Wishbone and IO pad bundle for the yblock wrapper
interface user_proj_yblock_if;
  logic         wbs_stb_i;
  logic         wbs_cyc_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i;
  logic [31:0]  wbs_adr_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in;
  logic [127:0] la_oen;
  logic [127:0] la_data_out;
  logic [37:0]  io_in;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output la_data_in, la_oen, io_in,
    input  wbs_ack_o, wbs_dat_o, la_data_out, io_out, io_oeb
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  la_data_in, la_oen, io_in,
    output wbs_ack_o, wbs_dat_o, la_data_out, io_out, io_oeb
  );
endinterface

// File: rtl/user_proj_yblock.sv
// rtl/user_proj_yblock.sv - 16x16 dual-rail cell array configured through per-column LA shift chains
// Optional YBLOCK_OUTREG_EN registers the bottom data output for one cycle of latency.
module user_proj_yblock #(
  parameter int N    = 16,
  parameter int CFGW = 2
) (
  input  logic vdda1,
  input  logic vdda2,
  input  logic vssa1,
  input  logic vssa2,
  input  logic vccd1,
  input  logic vccd2,
  input  logic vssd1,
  input  logic vssd2,
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  user_proj_yblock_if.slave bus
);
  localparam int SW        = N * CFGW;
  localparam int BRST_BIT  = 113;
  localparam int SHIFT_BIT = 112;
  localparam int CFG_LSB   = 96;
  localparam int DIN_LSB   = 64;

  logic              rst_n_int;
  logic              shift_en;
  logic [SW-1:0]     cfg_q [N];
  logic [SW-1:0]     cfg_d [N];
  logic [N-1:0]      cfg_tail;
  logic [2*N-1:0]    arr_out;
  logic [2*N-1:0]    dout;
  logic              unused_ok;

  // Either reset source clears every chain immediately and overrides a shift.
  assign rst_n_int = wb_rst_i & ~bus.la_data_in[BRST_BIT];
  assign shift_en  = bus.la_data_in[SHIFT_BIT];

  always_comb begin
    for (int c = 0; c < N; c++) begin
      cfg_d[c] = cfg_q[c];
      if (shift_en) cfg_d[c] = {cfg_q[c][SW-2:0], bus.la_data_in[CFG_LSB+c]};
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int c = 0; c < N; c++) cfg_q[c] <= '0;
    end else begin
      for (int c = 0; c < N; c++) cfg_q[c] <= cfg_d[c];
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) cfg_tail[c] = cfg_q[c][SW-1];
  end

  function automatic logic [1:0] clean(input logic [1:0] x);
    return (x == 2'b11) ? 2'b00 : x;
  endfunction

  function automatic logic [1:0] cell_fn(input logic [1:0] mode,
                                         input logic [1:0] vin_raw,
                                         input logic [1:0] left_raw);
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    a   = clean(vin_raw);
    b   = clean(left_raw);
    res = 2'b00;
    case (mode)
      2'b00: res = a;
      2'b01: res = {a[0], a[1]};
      2'b10: res = 2'b00;
      default: begin
        if (a == 2'b10 && b == 2'b10)
          res = 2'b10;
        else if ((a == 2'b01 && b != 2'b00) || (b == 2'b01 && a != 2'b00))
          res = 2'b01;
        else
          res = 2'b00;
      end
    endcase
    return res;
  endfunction

  // Rows are evaluated top to bottom; within a row the join reads the cell to its left.
  always_comb begin : array_eval
    logic [1:0] vin  [N];
    logic [1:0] vout [N];
    logic [1:0] left;
    int         lidx;
    arr_out = '0;
    left    = 2'b00;
    lidx    = 0;
    for (int c = 0; c < N; c++) begin
      vin[c]  = bus.la_data_in[DIN_LSB+2*c +: 2];
      vout[c] = 2'b00;
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        lidx    = (c == 0) ? 0 : c - 1;
        left    = (c == 0) ? vin[c] : vout[lidx];
        vout[c] = cell_fn(cfg_q[c][CFGW*r +: 2], vin[c], left);
      end
      for (int c = 0; c < N; c++) vin[c] = vout[c];
    end
    for (int c = 0; c < N; c++) arr_out[2*c +: 2] = vin[c];
  end

`ifdef YBLOCK_OUTREG_EN
  logic [2*N-1:0] dout_q;
  logic [2*N-1:0] dout_d;

  always_comb dout_d = arr_out;

  always_ff @(posedge wb_clk_i or negedge rst_n_int) begin
    if (!rst_n_int) dout_q <= '0;
    else            dout_q <= dout_d;
  end

  assign dout = dout_q;
`else
  assign dout = arr_out;
`endif

  assign bus.la_data_out = {{(128-3*N){1'b0}}, cfg_tail, dout};
  assign bus.wbs_ack_o   = 1'b0;
  assign bus.wbs_dat_o   = '0;
  assign bus.io_out      = '0;
  assign bus.io_oeb      = '1;

  assign unused_ok = ^{vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2,
                       bus.wbs_stb_i, bus.wbs_cyc_i, bus.wbs_we_i, bus.wbs_sel_i,
                       bus.wbs_dat_i, bus.wbs_adr_i, bus.la_oen, bus.io_in,
                       bus.la_data_in[127:114], bus.la_data_in[63:0]};
endmodule

// File: tb/tb_user_proj_yblock.sv
// tb/tb_user_proj_yblock.sv - randomized scoreboard bench for user_proj_yblock
module tb_user_proj_yblock;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic wb_rst_i;
  logic pwr = 1'b1;
  logic gnd = 1'b0;

  user_proj_yblock_if bus();

  user_proj_yblock dut (
    .vdda1(pwr), .vdda2(pwr), .vssa1(gnd), .vssa2(gnd),
    .vccd1(pwr), .vccd2(pwr), .vssd1(gnd), .vssd2(gnd),
    .wb_clk_i(clk),
    .wb_rst_i(wb_rst_i),
    .bus(bus.slave)
  );

  typedef struct {
    logic [47:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_s [16];
  logic        p_sh, p_brst, p_rstn;
  logic [15:0] p_cin;

  // Dual-rail pair as a tri-valued signal: -1 null (also illegal), 0, 1.
  function automatic int dec(input logic [1:0] p);
    if (p == 2'b01) return 0;
    if (p == 2'b10) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v == 0) return 2'b01;
    if (v == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int join_fn(input int a, input int b);
    if (a == 1 && b == 1) return 1;
    if ((a == 0 && b >= 0) || (b == 0 && a >= 0)) return 0;
    return -1;
  endfunction

  function automatic logic [47:0] model_out(input logic [31:0] din);
    int          cur [16];
    int          nxt [16];
    int          m;
    int          l;
    logic [31:0] dout;
    logic [15:0] tails;
    for (int c = 0; c < 16; c++) cur[c] = dec(din[2*c +: 2]);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        m = 2 * int'(m_s[c][2*r+1]) + int'(m_s[c][2*r]);
        if (c == 0) l = cur[0];
        else        l = nxt[c-1];
        case (m)
          0: nxt[c] = cur[c];
          1: nxt[c] = (cur[c] < 0) ? -1 : 1 - cur[c];
          2: nxt[c] = -1;
          default: nxt[c] = join_fn(cur[c], l);
        endcase
      end
      cur = nxt;
    end
    for (int c = 0; c < 16; c++) begin
      dout[2*c +: 2] = enc(cur[c]);
      tails[c]       = m_s[c][31];
    end
    return {tails, dout};
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic drive(input logic sh, input logic [15:0] cin, input logic [31:0] din,
                       input logic brst, input logic rstn, input string name);
    logic [127:0] la;
    @(posedge clk);
    #1;
    if (p_sh && !p_brst && p_rstn)
      for (int c = 0; c < 16; c++) m_s[c] = {m_s[c][30:0], p_cin[c]};
    la = {$urandom, $urandom, $urandom, $urandom};
    la[113]    = brst;
    la[112]    = sh;
    la[111:96] = cin;
    la[95:64]  = din;
    bus.la_data_in = la;
    bus.la_oen     = {$urandom, $urandom, $urandom, $urandom};
    bus.io_in      = {$urandom, $urandom};
    bus.wbs_dat_i  = $urandom;
    bus.wbs_adr_i  = $urandom;
    bus.wbs_sel_i  = 4'($urandom);
    bus.wbs_stb_i  = 1'($urandom);
    bus.wbs_cyc_i  = 1'($urandom);
    bus.wbs_we_i   = 1'($urandom);
    wb_rst_i = rstn;
    if (brst || !rstn)
      for (int c = 0; c < 16; c++) m_s[c] = '0;
    sbq.push_back('{exp: model_out(din), name: name});
    p_sh = sh; p_cin = cin; p_brst = brst; p_rstn = rstn;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.name, {80'b0, bus.la_data_out[47:0]}, {80'b0, e.exp});
        chk("tieoff_zero", {bus.la_data_out[127:48], bus.wbs_ack_o, bus.wbs_dat_o, bus.io_out},
            128'b0);
        chk("io_oeb", {90'b0, bus.io_oeb}, {90'b0, 38'h3F_FFFF_FFFF});
      end
    end
  end

  initial begin : stimulus
    wb_rst_i = 1'b0;
    bus.la_data_in = '0; bus.la_oen = '0; bus.io_in = '0;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;
    p_sh = 1'b0; p_cin = '0; p_brst = 1'b0; p_rstn = 1'b0;
    for (int c = 0; c < 16; c++) m_s[c] = '0;

    drive(1'b0, 16'h0, 32'h5A5AA5A5, 1'b0, 1'b0, "reset_pass");
    drive(1'b0, 16'h0, 32'h5A5AA5A5, 1'b0, 1'b1, "idle_pass");
    drive(1'b0, 16'h0, 32'hFFFF0000, 1'b0, 1'b1, "illegal_as_null");

    repeat (31) drive(1'b1, 16'h0000, $urandom, 1'b0, 1'b1, "shift_zero");
    drive(1'b1, 16'hFFFF, $urandom, 1'b0, 1'b1, "shift_row0");
    drive(1'b0, 16'h0, 32'h5A5AA5A5, 1'b0, 1'b1, "row0_invert");

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'hFFFF, $urandom, 1'b0, 1'b1, "shift_block_hi");
      drive(1'b1, 16'h0000, $urandom, 1'b0, 1'b1, "shift_block_lo");
    end
    drive(1'b0, 16'h0, $urandom, 1'b0, 1'b1, "all_block");
    drive(1'b1, 16'h0, $urandom, 1'b0, 1'b1, "block_tail_shift");
    drive(1'b0, 16'h0, $urandom, 1'b0, 1'b1, "block_tail_after");

    repeat (32) drive(1'b1, 16'hFFFF, $urandom, 1'b0, 1'b1, "shift_join");
    drive(1'b0, 16'h0, 32'hAAAAAAAA, 1'b0, 1'b1, "join_all_one");
    drive(1'b0, 16'h0, 32'hAAAAAAA9, 1'b0, 1'b1, "join_col0_zero");
    drive(1'b0, 16'h0, 32'hAAAAAAA8, 1'b0, 1'b1, "join_col0_null");

    repeat (10) drive(1'b1, 16'($urandom), $urandom, 1'b0, 1'b1, "shift_partial");
    drive(1'b0, 16'h0, $urandom, 1'b1, 1'b1, "blk_rst_pulse");
    drive(1'b0, 16'h0, 32'h5A5AA5A5, 1'b0, 1'b1, "after_blk_rst");

    drive(1'b1, 16'hFFFF, $urandom, 1'b1, 1'b1, "shift_vs_blk_rst");
    drive(1'b0, 16'h0, 32'h5A5AA5A5, 1'b0, 1'b1, "blk_rst_wins");

    repeat (5) drive(1'b1, 16'hFFFF, $urandom, 1'b0, 1'b0, "rst_hold_shift");
    drive(1'b0, 16'h0, 32'h9A5AA5A6, 1'b0, 1'b1, "after_rst_hold");

    repeat (400)
      drive(1'(($urandom % 4) != 0), 16'($urandom), $urandom,
            1'(($urandom % 50) == 0), 1'(($urandom % 70) != 0), "random");

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
